// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundle of every handshake and datapath signal of alu_op_sequencer.
//   Modports:
//     slave  - the sequencer itself (accepts commands, drives the ALU operands,
//              returns tagged results).
//     master - the environment around it (command source, ALU, result consumer).
//   Signals:
//     cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel
//     alu_op/alu_a/alu_b                     : registered operands to the ALU
//     alu_y                                  : combinational ALU result
//     res_valid/res_ready/res_data/res_tag/res_err : result channel
//     busy                                   : FIFO non-empty or FSM not idle
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready are both high. Once valid is raised the payload is held
// stable until that edge; ready may change freely and never depends on a
// transfer in the same cycle.
interface alu_op_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;

    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_y;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
        output cmd_ready, alu_op, alu_a, alu_b,
               res_valid, res_data, res_tag, res_err, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
        input  cmd_ready, alu_op, alu_a, alu_b,
               res_valid, res_data, res_tag, res_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Requester-side front end for a 32-bit combinational ALU. Commands
//   {op, a, b} are queued in a DEPTH-entry FIFO together with a sequence tag,
//   issued one at a time on registered ALU operand outputs, and the ALU result
//   is captured one cycle later and returned with its tag.
//
//   Ports:
//     clk         - rising-edge clock
//     rst_n       - asynchronous active-low reset, synchronous release
//     bus         - alu_op_sequencer_if.slave (command, ALU and result signals)
//     dbg_state_o - current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//
//   Parameters:
//     DEPTH - command FIFO entries (power of two, >= 2)
//     TAG_W - width of the result tag / command sequence counter
//
//   Optional feature (macro ALU_CHECK_EN):
//     When defined, a reference model checks alu_y against the issued
//     operands during ISSUE and res_err flags a mismatch alongside res_data.
//     When undefined, res_err is constant 0.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus,
    output logic [1:0]           dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [TAG_W-1:0] tag_cnt_q;
    logic             ready_en_q;   // holds cmd_ready low until the first edge after reset release

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    cmd_t             head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    // No bypass: a pop in this cycle does not make room for a push in this cycle.
    assign bus.cmd_ready = ready_en_q && !fifo_full;
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign head       = fifo_q[rd_ptr_q];

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: tag_cnt_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_cnt_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                tag_cnt_q <= tag_cnt_q + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue / response FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   capture;      // ISSUE: sample alu_y into the result registers
    logic   release_res;  // RESP: result handed over this edge

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d = fifo_empty ? S_IDLE : S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            S_IDLE:  pop = !fifo_empty;
            S_ISSUE: capture = 1'b1;
            S_RESP: begin
                release_res = bus.res_ready;
                // Back-to-back: next command is loaded on the same edge the
                // current result is taken.
                pop         = bus.res_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;
    assign bus.busy    = !fifo_empty || (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // ALU operand registers (hold last issued values between operations)
    // ------------------------------------------------------------------
    logic [2:0]       alu_op_q;
    logic [31:0]      alu_a_q;
    logic [31:0]      alu_b_q;
    logic [TAG_W-1:0] pend_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            pend_tag_q <= '0;
        end else if (pop) begin
            alu_op_q   <= head.op;
            alu_a_q    <= head.a;
            alu_b_q    <= head.b;
            pend_tag_q <= head.tag;
        end
    end

    assign bus.alu_op = alu_op_q;
    assign bus.alu_a  = alu_a_q;
    assign bus.alu_b  = alu_b_q;

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic             res_valid_q;
    logic [31:0]      res_data_q;
    logic [TAG_W-1:0] res_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.alu_y;
            res_tag_q   <= pend_tag_q;
        end else if (release_res) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;

`ifdef ALU_CHECK_EN
    // Independent model of the ALU, evaluated on the registered operands.
    logic [31:0] model_y;
    logic        res_err_q;

    always_comb begin
        model_y = '0;
        case (alu_op_q)
            3'b000:  model_y = alu_a_q + alu_b_q;
            3'b001:  model_y = alu_a_q - alu_b_q;
            3'b010:  model_y = alu_a_q & alu_b_q;
            3'b011:  model_y = alu_a_q | alu_b_q;
            3'b100:  model_y = ~alu_a_q;
            3'b101:  model_y = ($signed(alu_a_q) < $signed(alu_b_q)) ? 32'd1 : 32'd0;
            default: model_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (capture) begin
            res_err_q <= (bus.alu_y != model_y);
        end else if (release_res) begin
            res_err_q <= 1'b0;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int EW    = 1 + TAG_W + 32;   // {err, tag, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.TAG_W(TAG_W)) bus();
  logic [1:0] dbg_state;

  alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- ALU model (environment) ----------------
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] alu_fault = 32'd0;
  always_comb bus.alu_y = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b) + alu_fault;

  // ---------------- counters / checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    sb_e;
  logic [TAG_W-1:0] mdl_tag = '0;
  int               n_acc = 0;
  int               n_res = 0;
  logic             exp_err;

`ifdef ALU_CHECK_EN
  assign exp_err = (alu_fault != 32'd0);
`else
  assign exp_err = 1'b0;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_tag = '0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        n_res++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_data", bus.res_data, sb_e[31:0]);
          check("sb_tag", 32'(bus.res_tag), 32'(sb_e[32 +: TAG_W]));
          check("sb_err", {31'd0, bus.res_err}, {31'd0, sb_e[EW-1]});
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back({exp_err, mdl_tag, ref_alu(bus.cmd_op, bus.cmd_a, bus.cmd_b) + alu_fault});
        mdl_tag = mdl_tag + 1'b1;
        n_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cmd_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_result();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.res_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    check({pfx, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({pfx, "_res_data"},  bus.res_data, 32'd0);
    check({pfx, "_res_tag"},   32'(bus.res_tag), 32'd0);
    check({pfx, "_res_err"},   {31'd0, bus.res_err}, 32'd0);
    check({pfx, "_alu_op"},    32'(bus.alu_op), 32'd0);
    check({pfx, "_alu_a"},     bus.alu_a, 32'd0);
    check({pfx, "_alu_b"},     bus.alu_b, 32'd0);
    check({pfx, "_busy"},      {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready_at_release", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("reset_ready_after_edge", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vt[12];

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] held;
    logic        have_held;
    logic        hs;
    int          acc0;
    int          res0;
    int          k;

    vt[0]  = '{3'd5, 32'hFFFF_FFFF, 32'd1,        32'd1};
    vt[1]  = '{3'd5, 32'd1,        32'hFFFF_FFFF, 32'd0};
    vt[2]  = '{3'd4, 32'd0,        32'd0,         32'hFFFF_FFFF};
    vt[3]  = '{3'd6, 32'd3,        32'd4,         32'd0};
    vt[4]  = '{3'd1, 32'd0,        32'd1,         32'hFFFF_FFFF};
    vt[5]  = '{3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vt[6]  = '{3'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0};
    vt[7]  = '{3'd7, 32'd9,        32'd9,         32'd0};
    vt[8]  = '{3'd0, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000};
    vt[9]  = '{3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    vt[10] = '{3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0};
    vt[11] = '{3'd1, 32'd10,       32'd3,         32'd7};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;

    // --- reset state ---
    do_reset();

    // --- single command latency: accepted at edge N ---
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 32'd5;
    bus.cmd_b     = 32'd7;
    @(posedge clk);                  // edge N
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("lat_n_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("lat_n_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);                  // after N+1
    check("lat_n1_alu_a", bus.alu_a, 32'd5);
    check("lat_n1_alu_b", bus.alu_b, 32'd7);
    check("lat_n1_res_valid", {31'd0, bus.res_valid}, 32'd0);
    @(negedge clk);                  // after N+2
    check("lat_n2_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("lat_n2_res_data", bus.res_data, 32'd12);
    check("lat_n2_res_tag", 32'(bus.res_tag), 32'd0);
    @(negedge clk);                  // after N+3, result taken
    check("lat_n3_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("lat_n3_busy", {31'd0, bus.busy}, 32'd0);
    check("lat_alu_hold_a", bus.alu_a, 32'd5);

    // --- table-driven vectors ---
    for (int i = 0; i < 12; i++) begin
      send_cmd(vt[i].op, vt[i].a, vt[i].b);
      wait_result();
      check($sformatf("tbl%0d_data", i), bus.res_data, vt[i].y);
      check($sformatf("tbl%0d_tag", i), 32'(bus.res_tag), 32'((i + 1) % 16));
    end

    // --- backpressure: DEPTH+1 accepted while res_ready is low ---
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    acc0 = n_acc;
    have_held = 1'b0;
    held = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hs = bus.cmd_ready;
      if (bus.res_valid && !have_held) begin
        held = bus.res_data;
        have_held = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        bus.cmd_op = 3'($urandom_range(0, 7));
        bus.cmd_a  = $urandom;
        bus.cmd_b  = $urandom;
      end
    end
    @(negedge clk);
    check("bp_accepted", 32'(n_acc - acc0), 32'd5);
    check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("bp_res_stable", bus.res_data, held);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    res0 = n_res;
    k = 0;
    while (n_res - res0 < 5 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("bp_results", 32'(n_res - res0), 32'd5);
    check("bp_busy_after", {31'd0, bus.busy}, 32'd0);

    // --- tag wrap: 17 commands after reset ---
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_cmd(3'd0, 32'(i), 32'd100);
      wait_result();
      check($sformatf("wrap%0d_tag", i), 32'(bus.res_tag), 32'(i % 16));
      check($sformatf("wrap%0d_data", i), bus.res_data, 32'(i + 100));
    end

    // --- randomized traffic checked by the scoreboard ---
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      if (!bus.cmd_valid || hs) begin
        bus.cmd_valid = ($urandom_range(0, 3) != 0);
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_a     = rnd_operand();
        bus.cmd_b     = rnd_operand();
      end
      bus.res_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    hs = bus.cmd_valid && bus.cmd_ready;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rnd_drain_left", 32'(exp_q.size()), 32'd0);
    check("rnd_busy_after", {31'd0, bus.busy}, 32'd0);

    // --- reset while in RESP with 3 queued ---
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    send_cmd(3'd0, 32'd1, 32'd1);
    send_cmd(3'd0, 32'd2, 32'd2);
    send_cmd(3'd0, 32'd3, 32'd3);
    send_cmd(3'd0, 32'd4, 32'd4);
    wait_result();
    check("rr_busy_before", {31'd0, bus.busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rr");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b1;
    send_cmd(3'd2, 32'h0000_F0F0, 32'h0000_FF00);
    wait_result();
    check("rr_new_data", bus.res_data, 32'h0000_F000);
    check("rr_new_tag", 32'(bus.res_tag), 32'd0);
    check("rr_new_err", {31'd0, bus.res_err}, 32'd0);
    @(negedge clk);
    check("rr_idle_busy", {31'd0, bus.busy}, 32'd0);

`ifdef ALU_CHECK_EN
    // --- faulted ALU returning y+1 ---
    alu_fault = 32'd1;
    send_cmd(3'd2, 32'h0000_F0F0, 32'h0000_FF00);
    wait_result();
    check("fault_data", bus.res_data, 32'h0000_F001);
    check("fault_err", {31'd0, bus.res_err}, 32'd1);
    @(posedge clk);
    #1;
    alu_fault = 32'd0;
    @(negedge clk);
    check("fault_err_cleared", {31'd0, bus.res_err}, 32'd0);
    send_cmd(3'd0, 32'd2, 32'd3);
    wait_result();
    check("nofault_err", {31'd0, bus.res_err}, 32'd0);
    check("nofault_data", bus.res_data, 32'd5);
    @(negedge clk);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
